// File: rtl/cim_readout.sv
// Readout engine for a compute-in-memory macro: it snapshots 36 product bytes,
// then reduces them LANES per clock into a byte sum and a total popcount.
module cim_readout #(
   parameter int LANES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  products [0:35],
   output logic        busy,
   output logic        result_valid,
   input  logic        result_ready,
   output logic [13:0] sum,
   output logic [8:0]  popcount,
   output logic        start_err
);

   localparam int         STEPS    = 36 / LANES;
   localparam logic [5:0] LAST_IDX = 6'(36 - LANES);
   localparam logic [5:0] LANES_W  = 6'(LANES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state;
   logic [7:0]  snap [0:35];
   logic [5:0]  idx;
   logic [13:0] acc_sum;
   logic [8:0]  acc_pop;
   logic [13:0] grp_sum;
   logic [8:0]  grp_pop;
   logic [13:0] nxt_sum;
   logic [8:0]  nxt_pop;

   // Reduce the current group of LANES snapshot bytes starting at idx.
   always_comb begin
      // NOTE: every comb output gets a default before the loop, so no path leaves it unassigned (no latch).
      grp_sum = '0;
      grp_pop = '0;
      for (int k = 0; k < LANES; k++) begin
         grp_sum = grp_sum + 14'(snap[idx + 6'(k)]);
         grp_pop = grp_pop + 9'($countones(snap[idx + 6'(k)]));
      end
      nxt_sum = acc_sum + grp_sum;
      nxt_pop = acc_pop + grp_pop;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         acc_sum      <= '0;
         acc_pop      <= '0;
         sum          <= '0;
         popcount     <= '0;
         busy         <= 1'b0;
         result_valid <= 1'b0;
         start_err    <= 1'b0;
         // NOTE: the snapshot is cleared on reset on purpose; a discarded job must leave no trace of its data.
         for (int i = 0; i < 36; i++) snap[i] <= '0;
      end else begin
         // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
         start_err <= start && (state != IDLE);
         case (state)
            IDLE: begin
               if (start) begin
                  for (int i = 0; i < 36; i++) snap[i] <= products[i];
                  acc_sum <= '0;
                  acc_pop <= '0;
                  idx     <= '0;
                  busy    <= 1'b1;
                  state   <= ACCUM;
               end
            end
            ACCUM: begin
               acc_sum <= nxt_sum;
               acc_pop <= nxt_pop;
               if (idx == LAST_IDX) begin
                  sum          <= nxt_sum;
                  popcount     <= nxt_pop;
                  result_valid <= 1'b1;
                  state        <= DONE;
               end else begin
                  idx <= idx + LANES_W;
               end
            end
            DONE: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               result_valid <= 1'b0;
               busy         <= 1'b0;
               state        <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cim_readout.sv
// Randomized bench for cim_readout: three instances (LANES 4, 1, 36) checked
// against a sum/popcount model of the bytes present at start acceptance.
module tb_cim_readout;

   logic        clk;
   logic        rst_n;
   logic [7:0]  products [0:35];
   logic        start_v [3];
   logic        ready_v [3];
   logic        busy_v  [3];
   logic        valid_v [3];
   logic        err_v   [3];
   logic [13:0] sum_v   [3];
   logic [8:0]  pop_v   [3];

   int tests = 0;
   int fails = 0;

   cim_readout #(.LANES(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .products(products),
      .busy(busy_v[0]), .result_valid(valid_v[0]), .result_ready(ready_v[0]),
      .sum(sum_v[0]), .popcount(pop_v[0]), .start_err(err_v[0]));

   cim_readout #(.LANES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .products(products),
      .busy(busy_v[1]), .result_valid(valid_v[1]), .result_ready(ready_v[1]),
      .sum(sum_v[1]), .popcount(pop_v[1]), .start_err(err_v[1]));

   cim_readout #(.LANES(36)) dut36 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .products(products),
      .busy(busy_v[2]), .result_valid(valid_v[2]), .result_ready(ready_v[2]),
      .sum(sum_v[2]), .popcount(pop_v[2]), .start_err(err_v[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int steps_of(input int d);
      return (d == 0) ? 9 : (d == 1) ? 36 : 1;
   endfunction

   // Reference: byte sum and bit count of the current product array.
   task automatic model(output int es, output int ep);
      es = 0;
      ep = 0;
      for (int i = 0; i < 36; i++) begin
         es += int'(products[i]);
         for (int b = 0; b < 8; b++) ep += int'(products[i][b]);
      end
   endtask

   task automatic fill_const(input logic [7:0] v);
      for (int i = 0; i < 36; i++) products[i] = v;
   endtask

   task automatic fill_rand();
      for (int i = 0; i < 36; i++) products[i] = 8'($urandom_range(0, 255));
   endtask

   task automatic wait_valid(input int d, output int n);
      n = 0;
      while (!valid_v[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
   endtask

   // One complete job: accept, optional product corruption, latency, stall, handshake.
   task automatic run_job(input int d, input bit corrupt, input int stall);
      int es, ep, n;
      @(negedge clk);
      model(es, ep);
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
      check("busy_after_accept", 32'(busy_v[d]), 1);
      if (corrupt) fill_const(8'hAA);
      wait_valid(d, n);
      check("latency", n, steps_of(d));
      check("sum", 32'(sum_v[d]), es);
      check("popcount", 32'(pop_v[d]), ep);
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("stall_valid", 32'(valid_v[d]), 1);
         check("stall_sum", 32'(sum_v[d]), es);
         check("stall_pop", 32'(pop_v[d]), ep);
      end
      ready_v[d] = 1'b1;
      @(negedge clk);
      ready_v[d] = 1'b0;
      check("valid_after_hs", 32'(valid_v[d]), 0);
      check("busy_after_hs", 32'(busy_v[d]), 0);
      check("sum_retained", 32'(sum_v[d]), es);
      check("pop_retained", 32'(pop_v[d]), ep);
   endtask

   initial begin
      int es, ep, n;
      bit seen;
      rst_n = 1'b0;
      for (int d = 0; d < 3; d++) begin
         start_v[d] = 1'b0;
         ready_v[d] = 1'b0;
      end
      fill_const(8'h00);
      #2;
      check("rst_busy", 32'(busy_v[0]), 0);
      check("rst_valid", 32'(valid_v[0]), 0);
      check("rst_sum", 32'(sum_v[0]), 0);
      check("rst_err", 32'(err_v[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Zero, all-ones across lane widths, snapshot honoured, stalled consumer.
      run_job(0, 1'b0, 0);
      fill_const(8'hFF);
      run_job(0, 1'b0, 0);
      run_job(1, 1'b0, 0);
      run_job(2, 1'b0, 0);
      for (int i = 0; i < 36; i++) products[i] = 8'(i);
      run_job(0, 1'b1, 0);
      fill_rand();
      run_job(0, 1'b0, 5);

      // Start during ACCUM and on the handshake edge.
      fill_rand();
      @(negedge clk);
      model(es, ep);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      check("err_accum_pulse", 32'(err_v[0]), 1);
      @(negedge clk);
      check("err_accum_clear", 32'(err_v[0]), 0);
      wait_valid(0, n);
      check("err_job_valid", 32'(valid_v[0]), 1);
      check("err_job_sum", 32'(sum_v[0]), es);
      check("err_job_pop", 32'(pop_v[0]), ep);
      ready_v[0] = 1'b1;
      start_v[0] = 1'b1;
      @(negedge clk);
      ready_v[0] = 1'b0;
      start_v[0] = 1'b0;
      check("err_hs_pulse", 32'(err_v[0]), 1);
      check("err_hs_valid", 32'(valid_v[0]), 0);
      check("err_hs_busy", 32'(busy_v[0]), 0);
      @(negedge clk);
      check("err_hs_clear", 32'(err_v[0]), 0);
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (busy_v[0]) seen = 1'b1;
      end
      check("no_extra_job", 32'(seen), 0);
      check("err_sum_kept", 32'(sum_v[0]), es);

      // Asynchronous reset in the middle of accumulation.
      fill_rand();
      @(negedge clk);
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 32'(busy_v[0]), 0);
      check("mid_rst_valid", 32'(valid_v[0]), 0);
      check("mid_rst_sum", 32'(sum_v[0]), 0);
      check("mid_rst_pop", 32'(pop_v[0]), 0);
      check("mid_rst_err", 32'(err_v[0]), 0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (15) begin
         @(negedge clk);
         if (valid_v[0] || busy_v[0]) seen = 1'b1;
      end
      check("no_result_after_rst", 32'(seen), 0);
      fill_const(8'h01);
      run_job(0, 1'b0, 0);

      // Randomized back-to-back jobs over all three lane widths.
      for (int j = 0; j < 18; j++) begin
         fill_rand();
         run_job(j % 3, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got 0 expected 1");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cim_readout.md
CIM_READOUT -- requirements
Module: cim_readout

Interface
REQ-001 SHALL have parameter LANES, default 4: products reduced per clock; legal values 1,2,3,4,6,9,12,18,36 (divisors of 36).
REQ-002 SHALL have derived constant STEPS = 36/LANES: accumulate cycles per job.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  job request; accepted only in IDLE.
REQ-006 SHALL have port products  input  [7:0] x [0:35]  CIM macro product array, element i = lane i.
REQ-007 SHALL have port busy  output  1  high in ACCUM and DONE.
REQ-008 SHALL have port result_valid  output  1  result available; high only in DONE.
REQ-009 SHALL have port result_ready  input  1  consumer accepts result.
REQ-010 SHALL have port sum  output  14  unsigned sum of all 36 product bytes (max 9180).
REQ-011 SHALL have port popcount  output  9  total set bits across all 288 product bits (max 288).
REQ-012 SHALL have port start_err  output  1  one-cycle pulse; start seen while not IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-014 IDLE + start=1 SHALL, at that edge: snapshot all 36 products into an internal register, clear accumulators, set index=0, go to ACCUM.
REQ-015 Snapshot SHALL be the only sampling of products; later changes to products SHALL NOT affect the job.
REQ-016 Each ACCUM edge SHALL add snapshot elements index..index+LANES-1 to the sum accumulator and their bit counts to the popcount accumulator, then advance index by LANES.
REQ-017 The edge that processes the last group (index = 36-LANES) SHALL go to DONE and load sum/popcount outputs with the final totals.
REQ-018 result_valid SHALL rise exactly STEPS edges after the start-accept edge (LANES=4: 9 edges).
REQ-019 Accumulators SHALL be wide enough to never overflow: 14 bits sum, 9 bits popcount; no saturation logic.
REQ-020 In DONE, result_valid, sum and popcount SHALL hold stable until an edge with result_ready=1.
REQ-021 DONE + result_ready=1 SHALL go to IDLE at that edge; result_valid deasserts; sum/popcount retain their values.
REQ-022 result_ready while not in DONE SHALL be ignored.
REQ-023 start in ACCUM or DONE SHALL be ignored for job purposes and SHALL pulse start_err for one cycle at the next edge.
REQ-024 start at the same edge as a DONE->IDLE handshake SHALL be treated as not-IDLE: ignored, start_err pulses; a new job needs start in a later IDLE cycle.
REQ-025 Back-to-back jobs SHALL be possible with one IDLE cycle between handshake and next accept.
REQ-026 busy SHALL be registered state decode, high from the accept edge through the handshake edge.

Reset
REQ-027 rst_n=0 SHALL asynchronously force: state IDLE, index 0, accumulators 0, snapshot 0, sum 0, popcount 0, busy 0, result_valid 0, start_err 0.
REQ-028 Reset mid-ACCUM or mid-DONE SHALL discard the job; no result emitted after deassertion.
REQ-029 First start SHALL be accepted no earlier than the first rising edge with rst_n=1.

Verification
REQ-030 All products=0x00, start, ready=1 -> result_valid after 9 edges (LANES=4), sum=0, popcount=0.
REQ-031 All products=0xFF -> sum=9180, popcount=288; repeat with LANES=1 (36 edges) and LANES=36 (1 edge), same values.
REQ-032 products[i]=i, change all products to 0xAA one cycle after accept -> sum=630, popcount=88 (snapshot honoured).
REQ-033 Job complete, result_ready low 5 cycles -> result_valid, sum, popcount stable for all 5; handshake edge -> IDLE, busy=0.
REQ-034 start pulsed in ACCUM cycle 3 and on the handshake edge -> start_err pulses twice; result unchanged; no extra job.
REQ-035 rst_n low during ACCUM cycle 5 -> all outputs 0 immediately; after release, fresh job of all 0x01 -> sum=36, popcount=36.
